// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: grants one of four writeback requesters
// (rt, rd, link, sp) per cycle and drives RegDst/RegWrite/WriteData to the bank.
module regwrite_arbiter #(
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic [3:0]        req,
    input  logic [4:0]        rt_idx,
    input  logic [4:0]        rd_idx,
    input  logic [DATA_W-1:0] data_rt,
    input  logic [DATA_W-1:0] data_rd,
    input  logic [DATA_W-1:0] data_link,
    input  logic [DATA_W-1:0] data_sp,
    output logic [3:0]        gnt,
    output logic [1:0]        RegDst,
    output logic              RegWrite,
    output logic [DATA_W-1:0] WriteData,
    output logic              busy,
    output logic              dbg_state
);

    // Handshake: req[i] is a level held until granted. gnt[i] is a one-cycle
    // registered pulse; the requester keeps req[i] high during that cycle and
    // must drop it on the edge that ends the pulse. The granted bit is masked
    // from arbitration so a held req is never granted twice in a row.

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_n;
    logic [1:0]        ptr_q;
    logic [1:0]        ptr_n;
    logic [3:0]        elig;
    logic              found;
    logic [1:0]        win;
    logic [1:0]        cand;
    logic              take;
    logic              zero_dst;
    logic [DATA_W-1:0] win_data;
    logic [3:0]        gnt_n;
    logic [1:0]        dst_n;
    logic              we_n;
    logic [DATA_W-1:0] wd_n;

    // Winner search. Iterating from the lowest to the highest priority lets
    // the last hit (highest priority) win without a priority-encoder chain.
    always_comb begin
        elig  = req & ~gnt;
        found = 1'b0;
        win   = 2'd0;
        cand  = 2'd0;
        if (FIXED_PRIO != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (elig[i]) begin
                    found = 1'b1;
                    win   = 2'(i);
                end
            end
        end else begin
            // Round-robin order is ptr+1, ptr+2, ptr+3, ptr; scan it backwards.
            for (int k = 4; k >= 1; k--) begin
                cand = ptr_q + 2'(k);
                if (elig[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
    end

    always_comb begin
        zero_dst = ((win == 2'd0) && (rt_idx == 5'd0)) ||
                   ((win == 2'd1) && (rd_idx == 5'd0));
        case (win)
            2'd0:    win_data = data_rt;
            2'd1:    win_data = data_rd;
            2'd2:    win_data = data_link;
            default: win_data = data_sp;
        endcase
    end

    assign take = !hold && found;

    always_comb begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        dst_n   = RegDst;
        we_n    = 1'b0;
        wd_n    = '0;
        ptr_n   = ptr_q;
        case (state_q)
            IDLE, WRITE: begin
                if (take) begin
                    state_n = WRITE;
                    gnt_n   = 4'b0001 << win;
                    dst_n   = win;
                    // Writes to $zero still consume the slot but never reach the bank.
                    we_n    = !zero_dst;
                    wd_n    = zero_dst ? '0 : win_data;
                    if (FIXED_PRIO == 0) begin
                        ptr_n = win;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd3;
            gnt       <= 4'b0000;
            RegDst    <= 2'b00;
            RegWrite  <= 1'b0;
            WriteData <= '0;
        end else begin
            state_q   <= state_n;
            ptr_q     <= ptr_n;
            gnt       <= gnt_n;
            RegDst    <= dst_n;
            RegWrite  <= we_n;
            WriteData <= wd_n;
        end
    end

    assign busy      = (state_q == WRITE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed scenarios plus randomized traffic,
// all checked against a per-cycle behavioural model of the arbitration rules.
module tb_regwrite_arbiter;

    localparam int DW = 32;
    localparam int VW = DW + 9;

    typedef struct {
        logic [3:0]    gnt;
        logic [1:0]    dst;
        logic          we;
        logic [DW-1:0] wd;
        logic          busy;
        int            ptr;
    } model_t;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          hold = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic [3:0]    req_fp = 4'b0000;
    logic [4:0]    rt_idx = 5'd1;
    logic [4:0]    rd_idx = 5'd1;
    logic [DW-1:0] data_rt = '0;
    logic [DW-1:0] data_rd = '0;
    logic [DW-1:0] data_link = '0;
    logic [DW-1:0] data_sp = '0;

    logic [3:0]    gnt, gnt_f;
    logic [1:0]    regdst, regdst_f;
    logic          regwrite, regwrite_f;
    logic [DW-1:0] wdata, wdata_f;
    logic          busy, busy_f;
    logic          dbg, dbg_f;

    regwrite_arbiter #(.DATA_W(DW), .FIXED_PRIO(0)) dut_rr (
        .clock(clock), .reset(reset), .hold(hold), .req(req),
        .rt_idx(rt_idx), .rd_idx(rd_idx),
        .data_rt(data_rt), .data_rd(data_rd), .data_link(data_link), .data_sp(data_sp),
        .gnt(gnt), .RegDst(regdst), .RegWrite(regwrite), .WriteData(wdata),
        .busy(busy), .dbg_state(dbg)
    );

    regwrite_arbiter #(.DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset), .hold(hold), .req(req_fp),
        .rt_idx(rt_idx), .rd_idx(rd_idx),
        .data_rt(data_rt), .data_rd(data_rd), .data_link(data_link), .data_sp(data_sp),
        .gnt(gnt_f), .RegDst(regdst_f), .RegWrite(regwrite_f), .WriteData(wdata_f),
        .busy(busy_f), .dbg_state(dbg_f)
    );

    wire [VW-1:0] obs_rr = {gnt, regdst, regwrite, wdata, busy, dbg};
    wire [VW-1:0] obs_fp = {gnt_f, regdst_f, regwrite_f, wdata_f, busy_f, dbg_f};

    int total = 0;
    int bad = 0;

    // ---------------- reference model / scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] exp_fp_q[$];
    model_t m_rr, m_fp;

    function automatic int pick(logic [3:0] elig, int ptr, bit fixed);
        if (fixed) begin
            for (int p = 3; p >= 0; p--) if (elig[p]) return p;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c = (ptr + k) % 4;
                if (elig[c]) return c;
            end
        end
        return -1;
    endfunction

    function automatic model_t reset_model();
        model_t m;
        m.gnt = 4'b0; m.dst = 2'b0; m.we = 1'b0; m.wd = '0; m.busy = 1'b0; m.ptr = 3;
        return m;
    endfunction

    function automatic model_t advance(model_t m, logic [3:0] r, bit fixed);
        model_t n = m;
        int w = pick(r & ~m.gnt, m.ptr, fixed);
        if (hold || w < 0) begin
            n.gnt = 4'b0; n.we = 1'b0; n.wd = '0; n.busy = 1'b0;
        end else begin
            n.gnt  = 4'(1 << w);
            n.dst  = 2'(w);
            n.busy = 1'b1;
            if ((w == 0 && rt_idx == 5'd0) || (w == 1 && rd_idx == 5'd0)) begin
                n.we = 1'b0; n.wd = '0;
            end else begin
                n.we = 1'b1;
                n.wd = (w == 0) ? data_rt : (w == 1) ? data_rd : (w == 2) ? data_link : data_sp;
            end
            if (!fixed) n.ptr = w;
        end
        return n;
    endfunction

    function automatic logic [VW-1:0] pack(model_t m);
        return {m.gnt, m.dst, m.we, m.wd, m.busy, m.busy};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rr = reset_model();
            m_fp = reset_model();
        end else begin
            m_rr = advance(m_rr, req, 1'b0);
            m_fp = advance(m_fp, req_fp, 1'b1);
        end
        exp_q.delete();
        exp_q.push_back(pack(m_rr));
        exp_fp_q.delete();
        exp_fp_q.push_back(pack(m_fp));
    end

    // ---------------- driver ----------------
    logic [3:0] drop = 4'b0;
    logic [3:0] drop_fp = 4'b0;

    // Advance to the next falling edge; requesters release bits granted in the
    // previous cycle, i.e. on the edge that ended their grant pulse.
    task automatic step();
        @(negedge clock);
        req     = req & ~drop;
        req_fp  = req_fp & ~drop_fp;
        drop    = gnt;
        drop_fp = gnt_f;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        drop = 4'b0; drop_fp = 4'b0;
        req = 4'b0; req_fp = 4'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clock);
        total++;
        if (obs_rr !== '0) begin
            bad++; $display("FAIL reset_held: got=%h exp=%h", obs_rr, {VW{1'b0}});
        end
        reset = 1'b0;
        step();
        total++;
        if (exp_q.size() != 1 || obs_rr !== exp_q[0] || obs_rr !== '0) begin
            bad++; $display("FAIL reset_idle: got=%h exp=0", obs_rr);
        end
    endtask

    task automatic test_single();
        req = 4'b0010; rd_idx = 5'd8; data_rd = 32'h1234;
        step();
        total++;
        if (obs_rr !== {4'b0010, 2'b01, 1'b1, 32'h0000_1234, 1'b1, 1'b1}) begin
            bad++; $display("FAIL single_grant: got=%h", obs_rr);
        end
        step();
        total++;
        if (obs_rr !== {4'b0000, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0} || obs_rr !== exp_q[0]) begin
            bad++; $display("FAIL single_idle: got=%h exp=%h", obs_rr, exp_q[0]);
        end
    endtask

    task automatic test_round_robin();
        int busy_cnt = 0;
        pulse_reset();
        data_rt = 32'h1111_0000; data_rd = 32'h2222_0000;
        data_link = 32'h3333_0000; data_sp = 32'h4444_0000;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy === 1'b1) busy_cnt++;
            total++;
            if (gnt !== 4'(1 << i) || obs_rr !== exp_q[0]) begin
                bad++; $display("FAIL rr_order[%0d]: got gnt=%b exp=%b", i, gnt, 4'(1 << i));
            end
        end
        step();
        total++;
        if (busy_cnt != 4 || busy !== 1'b0) begin
            bad++; $display("FAIL rr_busy: got busy_cycles=%0d busy=%b exp 4/0", busy_cnt, busy);
        end
    endtask

    task automatic test_zero();
        req = 4'b0001; rt_idx = 5'd0; data_rt = 32'hDEAD_BEEF;
        step();
        total++;
        if (gnt !== 4'b0001 || regwrite !== 1'b0 || wdata !== '0 || regdst !== 2'b00) begin
            bad++; $display("FAIL zero_rt: got gnt=%b we=%b wd=%h", gnt, regwrite, wdata);
        end
        step();
        req = 4'b0010; rd_idx = 5'd0; data_rd = 32'hCAFE_F00D;
        step();
        total++;
        if (gnt !== 4'b0010 || regwrite !== 1'b0 || wdata !== '0 || obs_rr !== exp_q[0]) begin
            bad++; $display("FAIL zero_rd: got gnt=%b we=%b wd=%h", gnt, regwrite, wdata);
        end
        step();
        rt_idx = 5'd3; rd_idx = 5'd4;
    endtask

    task automatic test_hold();
        hold = 1'b1; req = 4'b0100; data_link = 32'h0040_0104;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || obs_rr !== exp_q[0]) begin
                bad++; $display("FAIL hold_block[%0d]: got gnt=%b busy=%b", i, gnt, busy);
            end
        end
        hold = 1'b0;
        step();
        total++;
        if (obs_rr !== {4'b0100, 2'b10, 1'b1, 32'h0040_0104, 1'b1, 1'b1}) begin
            bad++; $display("FAIL hold_release: got=%h", obs_rr);
        end
        step();
    endtask

    task automatic test_async_reset();
        req = 4'b0001; data_rt = 32'h0000_00AA;
        step();
        total++;
        if (busy !== 1'b1 || gnt !== 4'b0001) begin
            bad++; $display("FAIL areset_pre: got busy=%b gnt=%b", busy, gnt);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0 || regwrite !== 1'b0 || busy !== 1'b0 || obs_rr !== exp_q[0]) begin
            bad++; $display("FAIL areset_drop: got gnt=%b we=%b busy=%b", gnt, regwrite, busy);
        end
        req = 4'b1000; data_sp = 32'h7FFF_EFF0;
        drop = 4'b0; drop_fp = 4'b0;
        #1 reset = 1'b0;
        step();
        total++;
        if (obs_rr !== {4'b1000, 2'b11, 1'b1, 32'h7FFF_EFF0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL areset_regrant: got=%h", obs_rr);
        end
        step();
    endtask

    task automatic test_fixed_prio();
        logic [3:0] order[3];
        order[0] = 4'b0100; order[1] = 4'b0010; order[2] = 4'b0001;
        req_fp = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (gnt_f !== order[i] || obs_fp !== exp_fp_q[0]) begin
                bad++; $display("FAIL fixed_order[%0d]: got=%b exp=%b", i, gnt_f, order[i]);
            end
        end
        step();
        total++;
        if (gnt_f !== 4'b0 || busy_f !== 1'b0) begin
            bad++; $display("FAIL fixed_idle: got gnt=%b busy=%b", gnt_f, busy_f);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step();
            total++;
            if (exp_q.size() != 1 || obs_rr !== exp_q[0] || $countones(gnt) > 1) begin
                bad++; $display("FAIL rand_rr[%0d]: got=%h exp=%h", c, obs_rr, exp_q[0]);
            end
            total++;
            if (exp_fp_q.size() != 1 || obs_fp !== exp_fp_q[0] || $countones(gnt_f) > 1) begin
                bad++; $display("FAIL rand_fp[%0d]: got=%h exp=%h", c, obs_fp, exp_fp_q[0]);
            end
            hold = ($urandom_range(0, 4) == 0);
            for (int b = 0; b < 4; b++) begin
                if (!req[b] && !drop[b] && $urandom_range(0, 2) == 0) req[b] = 1'b1;
                if (!req_fp[b] && !drop_fp[b] && $urandom_range(0, 2) == 0) req_fp[b] = 1'b1;
            end
            rt_idx    = 5'($urandom_range(0, 3));
            rd_idx    = 5'($urandom_range(0, 3));
            data_rt   = $urandom;
            data_rd   = $urandom;
            data_link = $urandom;
            data_sp   = $urandom;
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero();
        test_hold();
        test_async_reset();
        test_fixed_prio();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
